ternary_window_scheduler: RTL and testbench

Sequences the ternary select array across the Tm output-channel weight sets for each Tn*K*K feature window.
- Fetches one feature window from upstream via a valid/ready handshake.
- Reads Tm weight sets from the weight buffer in back-to-back order and pulses the array enable for each.
- Counts the array's completion pulses and tags each result with its output-channel index for the downstream accumulator.
- Repeats for a configured number of windows, then signals done.

---
 rtl/ternary_window_scheduler.sv | 152 +++++++++++++++
 tb/tb_ternary_window_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ternary_window_scheduler.sv
// ternary_window_scheduler: walks the Tm weight sets through the ternary select
// array for each fetched feature window, tags results with their channel index,
// and repeats for num_windows windows before pulsing done.
// Optional build macro TERNARY_SCHED_PERF_EN adds busy/stall cycle counters.
module ternary_window_scheduler #(
    parameter int unsigned Tm          = 4,
    parameter int unsigned M_IDX_WIDTH = 2,
    parameter int unsigned WIN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIN_WIDTH-1:0]   num_windows,
    input  logic                   feat_valid,
    output logic                   feat_ready,
    output logic                   wbuf_rd_en,
    output logic [M_IDX_WIDTH-1:0] wbuf_rd_addr,
    output logic                   array_enable,
    input  logic                   array_done,
    output logic                   res_valid,
    output logic [M_IDX_WIDTH-1:0] res_m_idx,
    output logic                   acc_clear,
    output logic                   window_done,
    output logic                   busy,
`ifdef TERNARY_SCHED_PERF_EN
    output logic [31:0]            perf_busy_cycles,
    output logic [31:0]            perf_stall_cycles,
`endif
    output logic                   done
);

    localparam int unsigned CNT_W = M_IDX_WIDTH + 1;
    localparam logic [M_IDX_WIDTH-1:0] LAST_M  = M_IDX_WIDTH'(Tm - 1);
    localparam logic [CNT_W-1:0]       TM_CNT  = CNT_W'(Tm);
    localparam logic [CNT_W-1:0]       TM_LAST = CNT_W'(Tm - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FEAT,
        ISSUE,
        DRAIN,
        NEXT,
        FINISH
    } state_t;

    state_t               state;
    logic [WIN_WIDTH-1:0] num_win_q;
    logic [WIN_WIDTH-1:0] win_cnt;
    logic [CNT_W-1:0]     done_cnt;
    logic                 count_done_c;

    // A completion pulse is accepted only while a window is in flight and not yet full.
    assign count_done_c = array_done && ((state == ISSUE) || (state == DRAIN))
                          && (done_cnt < TM_CNT);
    assign res_valid    = count_done_c;
    assign res_m_idx    = count_done_c ? done_cnt[M_IDX_WIDTH-1:0] : '0;

    // Window sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            num_win_q    <= '0;
            win_cnt      <= '0;
            done_cnt     <= '0;
            feat_ready   <= 1'b0;
            wbuf_rd_en   <= 1'b0;
            wbuf_rd_addr <= '0;
            array_enable <= 1'b0;
            acc_clear    <= 1'b0;
            window_done  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            feat_ready   <= 1'b0;
            acc_clear    <= 1'b0;
            window_done  <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            array_enable <= wbuf_rd_en;
            if (count_done_c) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        num_win_q <= num_windows;
                        win_cnt   <= '0;
                        state     <= (num_windows == '0) ? FINISH : WAIT_FEAT;
                    end
                end
                WAIT_FEAT: begin
                    if (feat_valid) begin
                        wbuf_rd_en   <= 1'b1;
                        wbuf_rd_addr <= '0;
                        done_cnt     <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wbuf_rd_addr == LAST_M) begin
                        wbuf_rd_en   <= 1'b0;
                        wbuf_rd_addr <= '0;
                        state        <= DRAIN;
                    end else begin
                        wbuf_rd_addr <= wbuf_rd_addr + M_IDX_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if ((done_cnt == TM_CNT) || (count_done_c && (done_cnt == TM_LAST))) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    feat_ready  <= 1'b1;
                    acc_clear   <= 1'b1;
                    window_done <= 1'b1;
                    win_cnt     <= win_cnt + WIN_WIDTH'(1);
                    state       <= (win_cnt == num_win_q - WIN_WIDTH'(1)) ? FINISH : WAIT_FEAT;
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TERNARY_SCHED_PERF_EN
    // Saturating busy/stall counters, cleared by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if ((state == WAIT_FEAT) && !feat_valid && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ternary_window_scheduler.sv
// Testbench for ternary_window_scheduler: randomized runs compared cycle by
// cycle against an event-time model derived from the window schedule.
module tb_ternary_window_scheduler;

    localparam int unsigned TM   = 4;
    localparam int unsigned MW   = 2;
    localparam int unsigned WW   = 16;
    localparam int unsigned LMAX = 160;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WW-1:0] num_windows;
    logic          feat_valid;
    logic          feat_ready;
    logic          wbuf_rd_en;
    logic [MW-1:0] wbuf_rd_addr;
    logic          array_enable;
    logic          array_done;
    logic          res_valid;
    logic [MW-1:0] res_m_idx;
    logic          acc_clear;
    logic          window_done;
    logic          busy;
    logic          done;
`ifdef TERNARY_SCHED_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [31:0]   perf_stall_cycles;
`endif

    ternary_window_scheduler #(.Tm(TM), .M_IDX_WIDTH(MW), .WIN_WIDTH(WW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_windows  (num_windows),
        .feat_valid   (feat_valid),
        .feat_ready   (feat_ready),
        .wbuf_rd_en   (wbuf_rd_en),
        .wbuf_rd_addr (wbuf_rd_addr),
        .array_enable (array_enable),
        .array_done   (array_done),
        .res_valid    (res_valid),
        .res_m_idx    (res_m_idx),
        .acc_clear    (acc_clear),
        .window_done  (window_done),
        .busy         (busy),
`ifdef TERNARY_SCHED_PERF_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {feat_ready, wbuf_rd_en, wbuf_rd_addr, array_enable, res_valid,
                  res_m_idx, acc_clear, window_done, busy, done};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scenario description and expected per-cycle outputs.
    int          n_win;
    int          stall [8];
    bit          spur_en;
    int          fin;
    int          len;
    int          stall_sum;
    int          sp_cyc;
    bit          fv     [LMAX];
    bit          spur   [LMAX];
    bit          e_fr   [LMAX];
    bit          e_rd   [LMAX];
    int          e_addr [LMAX];
    bit          e_ae   [LMAX];
    bit          e_rv   [LMAX];
    int          e_ridx [LMAX];
    bit          e_wd   [LMAX];
    bit          e_busy [LMAX];
    bit          e_done [LMAX];

    // Event-time model: start at cycle 0, first WAIT_FEAT at cycle 1.
    task automatic build_model();
        int wf;
        int a;
        for (int c = 0; c < LMAX; c++) begin
            fv[c] = 1'b1; spur[c] = 1'b0;
            e_fr[c] = 0; e_rd[c] = 0; e_addr[c] = 0; e_ae[c] = 0;
            e_rv[c] = 0; e_ridx[c] = 0; e_wd[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        end
        stall_sum = 0;
        wf = 1;
        fin = 1;
        for (int i = 0; i < n_win; i++) begin
            for (int k = 0; k < stall[i]; k++) fv[wf + k] = 1'b0;
            stall_sum += stall[i];
            a = wf + stall[i];
            if (spur_en) spur[a] = 1'b1;
            for (int m = 0; m < int'(TM); m++) begin
                e_rd[a + 1 + m]   = 1'b1;
                e_addr[a + 1 + m] = m;
                e_ae[a + 2 + m]   = 1'b1;
                e_rv[a + 3 + m]   = 1'b1;
                e_ridx[a + 3 + m] = m;
            end
            e_fr[a + TM + 4] = 1'b1;
            e_wd[a + TM + 4] = 1'b1;
            wf = a + TM + 4;
            fin = wf;
        end
        e_done[fin + 1] = 1'b1;
        for (int c = 1; c <= fin + 1; c++) e_busy[c] = 1'b1;
        if (spur_en) spur[fin + 2] = 1'b1;
        len = fin + 4;
        sp_cyc = spur_en ? int'($urandom_range(1, fin)) : -1;
    endtask

    function automatic logic [11:0] exp_vec(input int c);
        return {e_fr[c], e_rd[c], MW'(e_addr[c]), e_ae[c], e_rv[c], MW'(e_ridx[c]),
                e_wd[c], e_wd[c], e_busy[c], e_done[c]};
    endfunction

    // Drives one run; rst_cyc >= 0 aborts it with a reset in that cycle.
    task automatic run(input int sid, input int rst_cyc);
        logic ae_prev;
        int   last;
        ae_prev = 1'b0;
        last = (rst_cyc >= 0) ? rst_cyc + 6 : len;
        for (int c = 0; c < last; c++) begin
            rst         = (c == rst_cyc);
            start       = (c == 0) || (c == sp_cyc);
            num_windows = (c == 0) ? WW'(n_win) : WW'($urandom);
            feat_valid  = fv[c];
            array_done  = ae_prev | spur[c] | ((rst_cyc >= 0) && (c > rst_cyc) && (c <= rst_cyc + 3));
            @(negedge clk);
            if (rst_cyc >= 0 && c > rst_cyc)
                chk($sformatf("s%0d_rst_c%0d", sid, c), 32'(obs), 32'd0);
            else if (c != rst_cyc)
                chk($sformatf("s%0d_c%0d", sid, c), 32'(obs), 32'(exp_vec(c)));
            ae_prev = array_enable;
            @(posedge clk);
            #1;
        end
        rst = 1'b0; start = 1'b0; array_done = 1'b0; feat_valid = 1'b0;
`ifdef TERNARY_SCHED_PERF_EN
        if (rst_cyc >= 0) begin
            chk($sformatf("s%0d_perf_busy", sid), perf_busy_cycles, 32'd0);
            chk($sformatf("s%0d_perf_stall", sid), perf_stall_cycles, 32'd0);
        end else begin
            chk($sformatf("s%0d_perf_busy", sid), perf_busy_cycles, 32'(fin + 1));
            chk($sformatf("s%0d_perf_stall", sid), perf_stall_cycles, 32'(stall_sum));
        end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_windows = '0; feat_valid = 1'b0; array_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'(obs), 32'd0);
        @(posedge clk);
        #1;

        // Single window, feat_valid held high.
        n_win = 1; stall[0] = 0; spur_en = 1'b0;
        build_model(); run(0, -1);
        // Three back-to-back windows.
        n_win = 3; for (int i = 0; i < 3; i++) stall[i] = 0;
        build_model(); run(1, -1);
        // Zero windows goes straight to FINISH.
        n_win = 0;
        build_model(); run(2, -1);
        // Five-cycle upstream stall, plus ignored start and spurious array_done.
        n_win = 1; stall[0] = 5; spur_en = 1'b1;
        build_model(); run(3, -1);
        // Reset during ISSUE at m=2 (ISSUE starts at cycle 2).
        n_win = 2; stall[0] = 0; stall[1] = 0; spur_en = 1'b0;
        build_model(); run(4, 4);
        // Randomized runs.
        for (int s = 5; s < 13; s++) begin
            n_win = int'($urandom_range(0, 4));
            for (int i = 0; i < 8; i++) stall[i] = int'($urandom_range(0, 5));
            spur_en = 1'($urandom_range(0, 1));
            build_model(); run(s, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
